// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
// Next-PC generation stage of the instruction fetch unit. Holds the
// architectural fetch PC, presents it to the BTB, chooses the next PC
// (sequential, BTB-predicted or execute redirect) and issues valid/ready
// fetch requests. Every accepted request is recorded in a small metadata
// FIFO that decode drains for later branch resolution.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   fetch_en            enables request issue
//   lookup_pc           PC presented to the BTB (equals pc_q)
//   btb_hit/btb_target  same-cycle BTB prediction for lookup_pc
//   redirect_valid/pc   execute mispredict or jump redirect
//   req_valid/addr      fetch request to instruction memory
//   req_ready           instruction memory accepts the request
//   meta_valid          metadata FIFO non-empty
//   meta_pc             PC of the oldest accepted request
//   meta_pred_taken     BTB hit captured at acceptance
//   meta_pred_target    predicted next PC captured at acceptance
//   meta_ready          decode pops the head entry

module fetch_pc_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    META_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] lookup_pc,
  input  logic                  btb_hit,
  input  logic [ADDR_WIDTH-1:0] btb_target,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_ready,
  output logic                  meta_valid,
  output logic [ADDR_WIDTH-1:0] meta_pc,
  output logic                  meta_pred_taken,
  output logic [ADDR_WIDTH-1:0] meta_pred_target,
  input  logic                  meta_ready
);

  localparam int PW = $clog2(META_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Word-alignment mask applied to every externally supplied address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;

  logic [ADDR_WIDTH-1:0] pc_mem     [META_DEPTH];
  logic                  taken_mem  [META_DEPTH];
  logic [ADDR_WIDTH-1:0] target_mem [META_DEPTH];

  logic                  meta_full;
  logic                  handshake;
  logic                  do_pop;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] btb_target_aligned;
  logic [ADDR_WIDTH-1:0] redirect_pc_aligned;

  assign btb_target_aligned  = btb_target & ALIGN_MASK;
  assign redirect_pc_aligned = redirect_pc & ALIGN_MASK;

  // Predicted successor of the current PC; the sequential increment wraps
  // naturally at the top of the address space.
  assign next_pc = btb_hit ? btb_target_aligned : pc_q + ADDR_WIDTH'(4);

  assign meta_full  = (count_q == CW'(META_DEPTH));
  assign meta_valid = (count_q != '0);

  // A redirect suppresses the request in its own cycle, and a full FIFO
  // holds issue off so a push can never overflow it.
  assign req_valid = (state_q == RUN) && !redirect_valid && !meta_full;
  assign handshake = req_valid && req_ready;

  // A redirect flushes the FIFO, so a same-cycle pop is meaningless.
  assign do_pop = meta_ready && meta_valid && !redirect_valid;

  assign lookup_pc = pc_q;
  assign req_addr  = pc_q;

  // The head is read straight from flops; gating on meta_valid makes the
  // outputs read zero while the FIFO is empty instead of stale data.
  assign meta_pc          = meta_valid ? pc_mem[rd_ptr_q]     : '0;
  assign meta_pred_taken  = meta_valid ? taken_mem[rd_ptr_q]  : 1'b0;
  assign meta_pred_target = meta_valid ? target_mem[rd_ptr_q] : '0;

  // Issue state: IDLE until fetch is enabled, RUN until disabled. Leaving
  // RUN waits for a cycle with no outstanding request (or its acceptance) so
  // a presented request is never withdrawn. A redirect leaves the state alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (!redirect_valid) begin
      case (state_q)
        IDLE:    if (fetch_en) state_q <= RUN;
        RUN:     if (!fetch_en && (!req_valid || handshake)) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fetch PC: a redirect wins over everything; otherwise the PC only
  // advances on an accepted request, so req_addr holds through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc_aligned;
    end else if (handshake) begin
      pc_q <= next_pc;
    end
  end

  // FIFO pointers and occupancy. Push and pop together leave the count
  // unchanged; a redirect empties the FIFO outright.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (handshake) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      if (handshake && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !handshake) count_q <= count_q - CW'(1);
    end
  end

  // FIFO storage. Entries need no reset because the outputs are gated by
  // occupancy; the BTB prediction is captured only in the accept cycle.
  always_ff @(posedge clk) begin
    if (handshake) begin
      pc_mem[wr_ptr_q]     <= pc_q;
      taken_mem[wr_ptr_q]  <= btb_hit;
      target_mem[wr_ptr_q] <= next_pc;
    end
  end

endmodule
